// File: rtl/serial_adder.sv
// Bit-serial LSB-first ripple adder: one full-adder cell and a carry flop, W+1 cycles per op.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic         sub,
`endif
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         ovf
);

   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_sr_q, a_sr_d;
   logic [W-1:0]    b_sr_q, b_sr_d;
   logic [W-1:0]    res_q, res_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            cy_q, cy_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            c_out_q, c_out_d;
   logic            ovf_q, ovf_d;
   logic            load;
   logic            s_bit;
   logic            cy_next;
   logic            sub_in;
   logic            sub_cur;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_q, sub_d;

   assign sub_in  = sub;
   assign sub_cur = sub_q;
   assign sub_d   = load ? sub : sub_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
      end else begin
         sub_q <= sub_d;
      end
   end
`else
   assign sub_in  = 1'b0;
   assign sub_cur = 1'b0;
`endif

   // Full-adder cell shared by every bit position.
   assign s_bit   = a_sr_q[0] ^ b_sr_q[0] ^ cy_q;
   assign cy_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & cy_q) | (b_sr_q[0] & cy_q);

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      load    = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               load = 1'b1;
            end
         end
         StShift: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            res_d  = {s_bit, res_q[W-1:1]};
            cy_d   = cy_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
               state_d = StDone;
               sum_d   = res_d;
               // cy_q is the carry into bit W-1 on this cycle.
               c_out_d = cy_next ^ sub_cur;
               ovf_d   = cy_q ^ cy_next;
            end
         end
         StDone: begin
            if (start) begin
               load = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (load) begin
         state_d = StShift;
         a_sr_d  = a;
         b_sr_d  = b ^ {W{sub_in}};
         cy_d    = c_in ^ sub_in;
         cnt_d   = '0;
         res_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy  = (state_q == StShift);
   assign done  = (state_q == StDone);
   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an integer-arithmetic reference.
// Subtract cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 4;
   localparam int Mod = 1 << W;
   localparam int Half = 1 << (W - 1);

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] op_a, op_b;
   logic         op_cin, op_sub;
   logic [W-1:0] held_sum;
   logic         held_cout, held_ovf;

   serial_adder #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .c_in  (c_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .c_out (c_out),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {ovf, c_out, sum} from plain signed/unsigned integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic xc, input logic xs);
      int ua, ub, sa, sb, tot, st, r;
      logic co, ov;
      ua = int'(xa);
      ub = int'(xb);
      sa = (ua >= Half) ? ua - Mod : ua;
      sb = (ub >= Half) ? ub - Mod : ub;
      if (xs) begin
         tot = ua - ub - int'(xc);
         st  = sa - sb - int'(xc);
         co  = (tot < 0);
      end else begin
         tot = ua + ub + int'(xc);
         st  = sa + sb + int'(xc);
         co  = (tot >= Mod);
      end
      r  = (tot + 2 * Mod) % Mod;
      ov = (st > Half - 1) || (st < -Half);
      return {ov, co, r[W-1:0]};
   endfunction

   task automatic launch(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic xs);
      op_a   = xa;
      op_b   = xb;
      op_cin = xc;
      op_sub = xs;
      a      = xa;
      b      = xb;
      c_in   = xc;
      sub    = xs;
      start  = 1'b1;
   endtask

   // Consumes the accepting edge and the W shift edges; ends in the done cycle.
   // poke >= 1 injects a start (9+9) before that shift edge, which must be ignored.
   task automatic finish_op(input string tag, input int poke);
      logic [W+1:0] e;
      e = model(op_a, op_b, op_cin, op_sub);
      tick();
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      c_in  = 1'($urandom);
      check({tag, " busy0"}, busy, 1);
      check({tag, " done0"}, done, 0);
      check({tag, " hold"}, {held_ovf, held_cout, sum}, {ovf, c_out, held_sum});
      for (int i = 1; i < int'(W); i++) begin
         if (i == poke) begin
            a     = W'(9);
            b     = W'(9);
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         check({tag, " busy"}, busy, 1);
         check({tag, " nodone"}, done, 0);
      end
      if (poke == int'(W)) begin
         a     = W'(9);
         b     = W'(9);
         start = 1'b1;
      end
      tick();
      start = 1'b0;
      check({tag, " done"}, done, 1);
      check({tag, " busy_end"}, busy, 0);
      check({tag, " sum"}, sum, e[W-1:0]);
      check({tag, " c_out"}, c_out, e[W]);
      check({tag, " ovf"}, ovf, e[W+1]);
      held_sum  = e[W-1:0];
      held_cout = e[W];
      held_ovf  = e[W+1];
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, " idle_done"}, done, 0);
         check({tag, " idle_busy"}, busy, 0);
         check({tag, " idle_sum"}, sum, held_sum);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      sub       = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      held_sum  = '0;
      held_cout = 1'b0;
      held_ovf  = 1'b0;
      #3;
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst out", {ovf, c_out, sum}, 0);
      #10;
      rst_n = 1'b1;
      tick();

      launch(5, 3, 0, 0);
      finish_op("5+3", 0);
      idle_cycles("5+3", 1);
      launch(15, 1, 0, 0);
      finish_op("15+1", 0);
      idle_cycles("15+1", 2);
      launch(7, 7, 1, 0);
      finish_op("7+7+1", 0);
      idle_cycles("7+7+1", 1);

      launch(2, 2, 0, 0);
      finish_op("ignore", 2);
      idle_cycles("ignore", 6);

      // Async reset in the 2nd shift cycle aborts the op and clears the result.
      launch(6, 5, 0, 0);
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort busy", busy, 0);
      check("abort out", {ovf, c_out, sum}, 0);
      #2;
      rst_n     = 1'b1;
      held_sum  = '0;
      held_cout = 1'b0;
      held_ovf  = 1'b0;
      idle_cycles("abort", 8);
      check("abort cout", c_out, 0);
      launch(1, 1, 0, 0);
      finish_op("after_abort", 0);
      idle_cycles("after_abort", 1);

      // Back-to-back: new start held during the done cycle.
      launch(1, 1, 0, 0);
      finish_op("b2b_1", 0);
      launch(3, 4, 0, 0);
      finish_op("b2b_2", 0);
      idle_cycles("b2b", 1);

`ifdef SERIAL_ADDER_SUB_EN
      launch(3, 5, 0, 1);
      finish_op("3-5", 0);
      idle_cycles("3-5", 1);
      launch(9, 4, 1, 1);
      finish_op("9-4-1", 0);
      idle_cycles("9-4-1", 1);
`endif

      for (int k = 0; k < 60; k++) begin
         logic xs;
`ifdef SERIAL_ADDER_SUB_EN
         xs = 1'($urandom);
`else
         xs = 1'b0;
`endif
         launch(W'($urandom), W'($urandom), 1'($urandom), xs);
         finish_op("rand", 0);
         if ($urandom_range(0, 2) != 0) begin
            idle_cycles("rand", int'($urandom_range(1, 3)));
         end
      end
      start = 1'b0;
      idle_cycles("tail", 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder; one bit position per clock, LSB first, one full-adder cell plus carry flop.
- Sized for datapaths where area matters more than latency; companion to the team's combinational parallel subtract path.
- Operands are latched on a start handshake; the result is presented with a one-cycle done pulse.
- Result is held stable until the next accepted start.

Parameters:
- W, 4, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  W  operand A; latched when start is accepted.
- b  input  W  operand B; latched when start is accepted.
- c_in  input  1  carry into bit 0; latched when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum, c_out and ovf are valid.
- sum  output  W  result register.
- c_out  output  1  carry out of bit W-1.
- ovf  output  1  signed overflow = carry into bit W-1 XOR carry out of bit W-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0; shift registers, bit counter and carry flop cleared. Reset mid-operation aborts the operation; no done is issued afterwards.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1, load a/b into shift regs, carry flop <= c_in, counter <= 0, busy <= 1, go to SHIFT.
- SHIFT, each cycle:
  - s = a_sr[0]^b_sr[0]^cy; cy <= majority(a_sr[0], b_sr[0], cy).
  - Shift s into the MSB of the result shift register, which shifts right.
  - Shift a_sr and b_sr right by one; counter increments.
  - On the cycle processing bit W-1: record the carry into that bit for ovf. On the next edge go to DONE with sum = result register, c_out = final carry, ovf computed, busy <= 0.
- DONE: done=1 for exactly this one cycle, busy=0.
  - start=1 in DONE is accepted: load and go to SHIFT, same as IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start sampled at edge N -> busy=1 from N through the W SHIFT cycles -> done=1 in the cycle after edge N+W. Throughput is one operation per W+1 cycles.
- start while busy=1 is ignored. No queuing; a/b/c_in changes during SHIFT have no effect.
- sum, c_out and ovf change only at the edge entering DONE. They are held through IDLE and through the next SHIFT until that operation's DONE.
- Width rules: all arithmetic is modulo 2^W. The carry out of bit W-1 appears only on c_out.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with start.
  - sub=1 computes A - B - b_in, with c_in acting as borrow-in b_in: the B shift reg loads ~b, and the carry flop loads ~c_in.
  - c_out reports borrow-out (inverted final carry); ovf uses the same XOR rule on the internal carries.
  - sub=0 behaves exactly as the add-only build.
- Not defined: no sub port; add only.

Test Plan:
- W=4, a=5, b=3, c_in=0, start pulse -> busy high 4 cycles, done pulse on cycle 5; sum=8, c_out=0, ovf=1.
- a=15, b=1, c_in=0 -> sum=0, c_out=1, ovf=0. Then a=7, b=7, c_in=1 -> sum=15, c_out=0, ovf=1.
- Start a=2, b=2; pulse start with a=9, b=9 two cycles later (busy=1) -> second request ignored; done once, sum=4; no second done.
- Start a=6, b=5; assert rst_n=0 on the 2nd SHIFT cycle, release, wait 8 cycles -> sum=0, c_out=0, done never pulses; a new start a=1, b=1 then yields sum=2.
- Hold start=1 in the DONE cycle with a=3, b=4 (first op a=1, b=1) -> first done with sum=2; second op starts immediately; second done exactly 5 cycles later with sum=7.
- SERIAL_ADDER_SUB_EN: sub=1, a=3, b=5, c_in=0 -> sum=14, c_out=1 (borrow). Then sub=1, a=9, b=4, c_in=1 -> sum=4, c_out=0.
